// File: rtl/bram_arb.sv
// bram_arb: two-requester arbiter in front of a single-port-pair BRAM.
// After reset the whole memory is cleared, then requests from A and B are
// accepted one per cycle with round-robin priority on conflicts. Read data
// comes straight from the BRAM and is tagged to its owner through a
// two-stage pipeline that matches the command register plus BRAM latency.
module bram_arb #(
    parameter int WIDTH  = 32,
    parameter int LENGHT = 8,
    localparam int AW    = $clog2(LENGHT)
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             a_req_i,
    input  logic             a_we_i,
    input  logic [AW-1:0]    a_addr_i,
    input  logic [WIDTH-1:0] a_wdata_i,
    output logic             a_gnt_o,
    output logic             a_rvalid_o,
    output logic [WIDTH-1:0] a_rdata_o,

    input  logic             b_req_i,
    input  logic             b_we_i,
    input  logic [AW-1:0]    b_addr_i,
    input  logic [WIDTH-1:0] b_wdata_i,
    output logic             b_gnt_o,
    output logic             b_rvalid_o,
    output logic [WIDTH-1:0] b_rdata_o,

    output logic             init_done_o,

    output logic             mem_we_o,
    output logic [AW-1:0]    mem_wr_add_o,
    output logic [WIDTH-1:0] mem_wr_data_o,
    output logic             mem_rd_en_o,
    output logic [AW-1:0]    mem_rd_add_o,
    input  logic [WIDTH-1:0] mem_rd_data_i
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q;
    logic [AW-1:0]      cnt_q;
    logic               prio_b_q;       // 1: B wins the next conflict
    logic               init_done_q;
    logic               mem_we_q;
    logic [AW-1:0]      mem_wr_add_q;
    logic [WIDTH-1:0]   mem_wr_data_q;
    logic               mem_rd_en_q;
    logic [AW-1:0]      mem_rd_add_q;
    logic               rd1_valid_q;    // read command on the BRAM port this cycle
    logic               rd1_owner_q;    // 1: owned by B
    logic               rd2_valid_q;    // BRAM data for that read is on mem_rd_data_i
    logic               rd2_owner_q;

    logic               a_gnt_d;
    logic               b_gnt_d;
    logic               acc_d;
    logic               acc_we_d;
    logic [AW-1:0]      acc_addr_d;
    logic [WIDTH-1:0]   acc_wdata_d;

    // Grant selection and mux of the accepted request's fields.
    always_comb begin
        a_gnt_d     = 1'b0;
        b_gnt_d     = 1'b0;
        acc_we_d    = a_we_i;
        acc_addr_d  = a_addr_i;
        acc_wdata_d = a_wdata_i;
        if (state_q == ST_RUN) begin
            a_gnt_d = a_req_i && (!b_req_i || !prio_b_q);
            b_gnt_d = b_req_i && (!a_req_i ||  prio_b_q);
        end
        if (b_gnt_d) begin
            acc_we_d    = b_we_i;
            acc_addr_d  = b_addr_i;
            acc_wdata_d = b_wdata_i;
        end
        acc_d = a_gnt_d || b_gnt_d;
    end

    // Clear/run state machine with registered BRAM commands and read-owner tags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_INIT;
            cnt_q         <= '0;
            prio_b_q      <= 1'b0;
            init_done_q   <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_wr_add_q  <= '0;
            mem_wr_data_q <= '0;
            mem_rd_en_q   <= 1'b0;
            mem_rd_add_q  <= '0;
            rd1_valid_q   <= 1'b0;
            rd1_owner_q   <= 1'b0;
            rd2_valid_q   <= 1'b0;
            rd2_owner_q   <= 1'b0;
        end else begin
            rd2_valid_q <= rd1_valid_q;
            rd2_owner_q <= rd1_owner_q;
            case (state_q)
                ST_INIT: begin
                    mem_we_q      <= 1'b1;
                    mem_wr_add_q  <= cnt_q;
                    mem_wr_data_q <= '0;
                    mem_rd_en_q   <= 1'b0;
                    rd1_valid_q   <= 1'b0;
                    rd1_owner_q   <= 1'b0;
                    cnt_q         <= cnt_q + AW'(1);
                    if (cnt_q == AW'(LENGHT - 1)) begin
                        state_q     <= ST_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    mem_we_q    <= acc_d && acc_we_d;
                    mem_rd_en_q <= acc_d && !acc_we_d;
                    rd1_valid_q <= acc_d && !acc_we_d;
                    rd1_owner_q <= b_gnt_d;
                    if (acc_d && acc_we_d) begin
                        mem_wr_add_q  <= acc_addr_d;
                        mem_wr_data_q <= acc_wdata_d;
                    end
                    if (acc_d && !acc_we_d) begin
                        mem_rd_add_q <= acc_addr_d;
                    end
                    // Point at the side that lost (or did not ask) this time.
                    if (acc_d) begin
                        prio_b_q <= a_gnt_d;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign a_gnt_o       = a_gnt_d;
    assign b_gnt_o       = b_gnt_d;
    assign a_rvalid_o    = rd2_valid_q && !rd2_owner_q;
    assign b_rvalid_o    = rd2_valid_q &&  rd2_owner_q;
    assign a_rdata_o     = mem_rd_data_i;
    assign b_rdata_o     = mem_rd_data_i;
    assign init_done_o   = init_done_q;
    assign mem_we_o      = mem_we_q;
    assign mem_wr_add_o  = mem_wr_add_q;
    assign mem_wr_data_o = mem_wr_data_q;
    assign mem_rd_en_o   = mem_rd_en_q;
    assign mem_rd_add_o  = mem_rd_add_q;

endmodule

// File: doc/bram_arb.md
BRAM_ARB -- requirements
Module: bram_arb

Interface
REQ-001 Parameter WIDTH, default 32, memory data width in bits.
REQ-002 Parameter LENGHT, default 8, memory depth in words; address width AW = 3 (log2 LENGHT).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous assert, active-low (0 = in reset).
REQ-005 a_req, a_we  in  1 each  requester A: request valid; 1 = write, 0 = read.
REQ-006 a_addr  in  AW; a_wdata  in  WIDTH  requester A address and write data.
REQ-007 a_gnt  out  1  A request accepted this cycle (combinational).
REQ-008 a_rvalid  out  1; a_rdata  out  WIDTH  A read data, valid only while a_rvalid=1.
REQ-009 b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: requester B, identical to REQ-005..008.
REQ-010 init_done  out  1  memory clear finished; requests may be accepted.
REQ-011 mem_we  out  1; mem_wr_add  out  AW; mem_wr_data  out  WIDTH  BRAM write port.
REQ-012 mem_rd_en  out  1; mem_rd_add  out  AW  BRAM read port.
REQ-013 mem_rd_data  in  WIDTH  BRAM read data, registered by BRAM one cycle after mem_rd_en.

Function
REQ-014 FSM states INIT and RUN; reset enters INIT with clear counter = 0.
REQ-015 INIT: each cycle register mem_we=1, mem_wr_add=counter, mem_wr_data=0; counter +1; after the write of address LENGHT-1 is issued, go to RUN.
REQ-016 INIT lasts exactly LENGHT cycles; init_done=0 in INIT, 1 in RUN; a_gnt=b_gnt=0 throughout INIT.
REQ-017 RUN: a request is accepted in the cycle x_req=1 and x_gnt=1; x_req=1 with x_gnt=0 has no effect, so the requester holds req and its fields until granted.
REQ-018 At most one grant per cycle; only one requesting -> grant it; both requesting -> grant the side named by priority pointer.
REQ-019 Priority pointer resets to A; after any grant it points to the non-granted side; unchanged in cycles without a grant.
REQ-020 Accepted write at cycle T: in T+1, mem_we=1, mem_wr_add/mem_wr_data = accepted addr/wdata, mem_rd_en=0.
REQ-021 Accepted read at cycle T: in T+1, mem_rd_en=1, mem_rd_add = accepted addr, mem_we=0; in T+2, x_rvalid=1 for the owner only and x_rdata = mem_rd_data.
REQ-022 Cycle with no acceptance (RUN): mem_we=0, mem_rd_en=0 next cycle; mem_* command outputs are registered.
REQ-023 mem_we and mem_rd_en are never both 1 in the same cycle.
REQ-024 Write accepted at T, read of same address accepted at T+1 (either requester): read returns the new data.
REQ-025 Back-to-back accepted reads sustain one rvalid per cycle in acceptance order, each routed to its own requester via a 2-stage owner tag pipeline.
REQ-026 a_rdata and b_rdata are unspecified when the matching rvalid is 0.

Reset
REQ-027 rst=0 immediately forces: state INIT, counter 0, priority A, mem_we=0, mem_rd_en=0, mem_wr_add=0, mem_wr_data=0, mem_rd_add=0, a_rvalid=b_rvalid=0, init_done=0, owner tags cleared.
REQ-028 Reset during any operation drops in-flight reads (no rvalid ever returned) and reruns the full INIT clear after release.
REQ-029 The first INIT write (address 0) is issued in the first cycle after rst returns to 1.

Verification
REQ-030 Release reset -> mem_we=1 for 8 cycles with mem_wr_add 0..7, data 0; init_done=1 in cycle 9; A read of address 5 returns 0x00000000.
REQ-031 A writes 0xDEADBEEF to address 3, then reads address 3 -> a_rvalid=1 two cycles after read acceptance, a_rdata=0xDEADBEEF, b_rvalid stays 0.
REQ-032 a_req=b_req=1 held continuously in RUN from reset -> grants A,B,A,B,...; mem_* commands alternate accordingly.
REQ-033 A writes 0x12345678 to address 7 at T, B reads address 7 at T+1 -> b_rvalid at T+3 with b_rdata=0x12345678.
REQ-034 a_req=1 held from reset -> a_gnt=0 for all 8 INIT cycles, a_gnt=1 in the first RUN cycle.
REQ-035 Assert rst one cycle after an A read acceptance -> a_rvalid never asserts; 8-cycle clear repeats after release.
